// File: rtl/bin2bcd_periph.sv
// Memory-mapped 16-bit binary to 5-digit packed BCD converter (iterative double-dabble).
// Optional macro BCD_SIGNED_EN: treat BIN as two's complement and report the sign.
module bin2bcd_periph #(
   parameter int DW = 16
) (
   input  logic          CLK,
   input  logic          reset,
   input  logic [DW-1:0] d_in,
   input  logic          cs,
   input  logic [4:0]    addr,
   input  logic          rd,
   input  logic          wr,
   output logic [DW-1:0] d_out,
   output logic          done
);

   localparam logic [4:0] ADDR_BIN    = 5'h04;
   localparam logic [4:0] ADDR_START  = 5'h0C;
   localparam logic [4:0] ADDR_BCDLO  = 5'h10;
   localparam logic [4:0] ADDR_BCDHI  = 5'h14;
   localparam logic [4:0] ADDR_STATUS = 5'h18;

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, FIN} state_t;

   state_t      state;
   state_t      state_next;
   logic [15:0] bin_q;
   logic [15:0] shift_q;
   logic [15:0] shift_nxt;
   logic [15:0] magnitude;
   logic [19:0] bcd_q;
   logic [19:0] bcd_adj;
   logic [19:0] bcd_nxt;
   logic [19:0] result_q;
   logic [3:0]  count_q;
   logic        done_q;
   logic        busy;
   logic        wr_en;
   logic        start_req;
   logic        sign_flag;
   logic [15:0] rd_mux;

   // Bus handshake: no valid/ready; a cycle with cs&wr is a write, cs&rd a read,
   // and read data lands in d_out on the edge that samples the strobe.
   assign wr_en     = cs & wr;
   assign start_req = wr_en && (addr == ADDR_START) && d_in[0];
   assign busy      = (state == LOAD) || (state == SHIFT);
   assign done      = done_q;

   always_ff @(posedge CLK) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // FIN is a one-cycle settle state; it accepts a new START like IDLE does.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start_req) state_next = LOAD;
         LOAD:    state_next = SHIFT;
         SHIFT:   if (count_q == 4'd15) state_next = FIN;
         FIN:     state_next = start_req ? LOAD : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < 5; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
      bcd_nxt   = {bcd_adj[18:0], shift_q[15]};
      shift_nxt = {shift_q[14:0], 1'b0};
   end

`ifdef BCD_SIGNED_EN
   logic sign_q;
   logic sign_res_q;

   assign magnitude = bin_q[15] ? (~bin_q + 16'd1) : bin_q;
   assign sign_flag = sign_res_q;

   always_ff @(posedge CLK) begin
      if (reset) begin
         sign_q     <= 1'b0;
         sign_res_q <= 1'b0;
      end else begin
         if (state == LOAD) sign_q <= bin_q[15];
         if (state == SHIFT && count_q == 4'd15) sign_res_q <= sign_q;
      end
   end
`else
   assign magnitude = bin_q;
   assign sign_flag = 1'b0;
`endif

   always_comb begin
      rd_mux = 16'h0000;
      case (addr)
         ADDR_BIN:    rd_mux = bin_q;
         ADDR_START:  rd_mux = {15'b0, busy};
         ADDR_BCDLO:  rd_mux = result_q[15:0];
         ADDR_BCDHI:  rd_mux = {sign_flag, 11'b0, result_q[19:16]};
         ADDR_STATUS: rd_mux = {13'b0, sign_flag, busy, done_q};
         default:     rd_mux = 16'h0000;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         bin_q    <= 16'h0000;
         shift_q  <= 16'h0000;
         bcd_q    <= 20'h00000;
         result_q <= 20'h00000;
         count_q  <= 4'd0;
         done_q   <= 1'b0;
         d_out    <= 16'h0000;
      end else begin
         d_out <= (cs && rd) ? rd_mux : 16'h0000;
         if (wr_en && addr == ADDR_BIN) bin_q <= d_in;
         if (state_next == LOAD) done_q <= 1'b0;
         if (state == LOAD) begin
            shift_q <= magnitude;
            bcd_q   <= 20'h00000;
            count_q <= 4'd0;
         end
         if (state == SHIFT) begin
            shift_q <= shift_nxt;
            bcd_q   <= bcd_nxt;
            count_q <= count_q + 4'd1;
            // The last shift publishes the result; visible readers never see partial digits.
            if (count_q == 4'd15) begin
               result_q <= bcd_nxt;
               done_q   <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_bin2bcd_periph.sv
// Directed bench for bin2bcd_periph with an arithmetic reference model checked every cycle.
module tb_bin2bcd_periph;

   logic        CLK = 1'b0;
   logic        reset;
   logic [15:0] d_in;
   logic        cs;
   logic [4:0]  addr;
   logic        rd;
   logic        wr;
   logic [15:0] d_out;
   logic        done;

   int n_tests = 0;
   int n_fail  = 0;

   bin2bcd_periph #(.DW(16)) dut (
      .CLK(CLK), .reset(reset), .d_in(d_in), .cs(cs), .addr(addr),
      .rd(rd), .wr(wr), .d_out(d_out), .done(done)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: plain decimal arithmetic plus a cycle countdown.
   function automatic logic [19:0] bcd5(input int v);
      logic [19:0] r;
      r = '0;
      for (int k = 0; k < 5; k++) begin
         r[4*k +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   logic [15:0] m_bin;
   logic [19:0] m_res;
   logic        m_done;
   logic        m_rsign;
   logic        m_osign;
   int          m_opnd;
   int          m_cnt;
   logic [15:0] m_dout;
   logic        model_live = 1'b0;

   function automatic logic [15:0] model_read(input logic [4:0] a);
      logic b;
      b = (m_cnt != 0);
      case (a)
         5'h04:   return m_bin;
         5'h0C:   return {15'b0, b};
         5'h10:   return m_res[15:0];
         5'h14:   return {m_rsign, 11'b0, m_res[19:16]};
         5'h18:   return {13'b0, m_rsign, b, m_done};
         default: return 16'h0000;
      endcase
   endfunction

   always @(posedge CLK) begin
      model_live <= 1'b1;
      if (reset) begin
         m_bin = 0; m_res = 0; m_done = 0; m_rsign = 0; m_osign = 0;
         m_opnd = 0; m_cnt = 0; m_dout = 0;
      end else begin
         m_dout = (cs && rd) ? model_read(addr) : 16'h0000;
         if (m_cnt != 0) begin
            if (m_cnt == 17) begin
`ifdef BCD_SIGNED_EN
               m_osign = m_bin[15];
               m_opnd  = m_bin[15] ? 65536 - int'(m_bin) : int'(m_bin);
`else
               m_osign = 1'b0;
               m_opnd  = int'(m_bin);
`endif
            end
            m_cnt--;
            if (m_cnt == 0) begin
               m_res   = bcd5(m_opnd);
               m_rsign = m_osign;
               m_done  = 1'b1;
            end
         end else if (cs && wr && addr == 5'h0C && d_in[0]) begin
            m_cnt  = 17;
            m_done = 1'b0;
         end
         if (cs && wr && addr == 5'h04) m_bin = d_in;
      end
   end

   always @(negedge CLK) begin
      if (model_live) begin
         check("model_done", {15'b0, done}, {15'b0, m_done});
         check("model_dout", d_out, m_dout);
      end
   end

   task automatic bus_write(input logic [4:0] a, input logic [15:0] d);
      @(negedge CLK);
      cs = 1; wr = 1; rd = 0; addr = a; d_in = d;
      @(negedge CLK);
      cs = 0; wr = 0;
   endtask

   task automatic expect_read(input string name, input logic [4:0] a, input logic [15:0] exp);
      @(negedge CLK);
      cs = 1; rd = 1; wr = 0; addr = a;
      @(negedge CLK);
      cs = 0; rd = 0;
      check(name, d_out, exp);
   endtask

   task automatic wait_done(input string name);
      int k;
      for (k = 0; k < 40; k++) begin
         if (done) break;
         @(negedge CLK);
      end
      check(name, {15'b0, done}, 16'h0001);
   endtask

   task automatic convert(input string name, input logic [15:0] v);
      bus_write(5'h04, v);
      bus_write(5'h0C, 16'h0001);
      wait_done(name);
   endtask

   initial begin
      reset = 1; cs = 0; rd = 0; wr = 0; addr = 0; d_in = 0;
      repeat (3) @(negedge CLK);
      reset = 0;
      expect_read("reset_bin", 5'h04, 16'h0000);
      expect_read("reset_status", 5'h18, 16'h0000);
      expect_read("reset_bcdlo", 5'h10, 16'h0000);

      // Basic 900 with exact latency
      bus_write(5'h04, 16'd900);
      bus_write(5'h0C, 16'h0001);
      repeat (16) @(negedge CLK);
      check("latency_e16_low", {15'b0, done}, 16'h0000);
      @(negedge CLK);
      check("latency_e17_high", {15'b0, done}, 16'h0001);
      expect_read("basic_lo", 5'h10, 16'h0900);
      expect_read("basic_hi", 5'h14, 16'h0000);
      expect_read("basic_status", 5'h18, 16'h0001);

      // START with d_in[0]=0 is ignored
      bus_write(5'h0C, 16'h0000);
      expect_read("start0_status", 5'h18, 16'h0001);
      expect_read("start0_busy", 5'h0C, 16'h0000);

      // Max value, with reads while busy returning the old result
      bus_write(5'h04, 16'hFFFF);
      bus_write(5'h0C, 16'h0001);
      expect_read("busy_status", 5'h18, 16'h0002);
      expect_read("busy_old_lo", 5'h10, 16'h0900);
      expect_read("busy_start_reg", 5'h0C, 16'h0001);
      wait_done("max_done");
      expect_read("max_lo", 5'h10, 16'h5535);
      expect_read("max_hi", 5'h14, 16'h0006);

      convert("zero_done", 16'h0000);
      expect_read("zero_lo", 5'h10, 16'h0000);
      expect_read("zero_hi", 5'h14, 16'h0000);
      expect_read("zero_status", 5'h18, 16'h0001);

      // Busy protection
      bus_write(5'h04, 16'd1234);
      bus_write(5'h0C, 16'h0001);
      repeat (2) @(negedge CLK);
      bus_write(5'h04, 16'd42);
      bus_write(5'h0C, 16'h0001);
      wait_done("busy_prot_done");
      expect_read("busy_prot_lo", 5'h10, 16'h1234);
      expect_read("busy_prot_bin", 5'h04, 16'd42);
      repeat (3) @(negedge CLK);
      check("no_restart", {15'b0, done}, 16'h0001);
      bus_write(5'h0C, 16'h0001);
      wait_done("second_done");
      expect_read("second_lo", 5'h10, 16'h0042);

      // Reset mid-conversion
      bus_write(5'h04, 16'd999);
      bus_write(5'h0C, 16'h0001);
      repeat (6) @(negedge CLK);
      reset = 1;
      @(negedge CLK);
      check("rst_mid_done", {15'b0, done}, 16'h0000);
      check("rst_mid_dout", d_out, 16'h0000);
      reset = 0;
      expect_read("rst_mid_status", 5'h18, 16'h0000);
      expect_read("rst_mid_lo", 5'h10, 16'h0000);
      expect_read("rst_mid_bin", 5'h04, 16'h0000);
      convert("after_rst_done", 16'd7);
      expect_read("after_rst_lo", 5'h10, 16'h0007);

      // Simultaneous read and write returns the pre-write value
      @(negedge CLK);
      cs = 1; rd = 1; wr = 1; addr = 5'h04; d_in = 16'h00AA;
      @(negedge CLK);
      cs = 0; rd = 0; wr = 0;
      check("rdwr_old", d_out, 16'h0007);
      expect_read("rdwr_new", 5'h04, 16'h00AA);
      expect_read("unmapped", 5'h08, 16'h0000);

      // Sign handling
      convert("neg_done", 16'hFF85);
`ifdef BCD_SIGNED_EN
      expect_read("neg_lo", 5'h10, 16'h0123);
      expect_read("neg_hi", 5'h14, 16'h8000);
      expect_read("neg_status", 5'h18, 16'h0005);
`else
      expect_read("neg_lo", 5'h10, 16'h5413);
      expect_read("neg_hi", 5'h14, 16'h0006);
      expect_read("neg_status", 5'h18, 16'h0001);
`endif
      convert("min_done", 16'h8000);
      expect_read("min_lo", 5'h10, 16'h2768);
`ifdef BCD_SIGNED_EN
      expect_read("min_hi", 5'h14, 16'h8003);
`else
      expect_read("min_hi", 5'h14, 16'h0003);
`endif

      repeat (2) @(negedge CLK);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bin2bcd_periph.md
Name: bin2bcd_periph

Overview:
- Memory-mapped binary-to-BCD converter peripheral on the calculator bus; sits directly downstream of the divider peripheral.
- The sequencer writes the 16-bit quotient read from the divider into this block, pulses START, and reads back 5 packed BCD digits for the display driver.
- Iterative double-dabble: one shift per clock, add-3 correction on each digit before the shift.
- Bus protocol (CLK, reset, cs, rd, wr, addr[4:0], d_in/d_out[15:0]) matches the divider peripheral.

Parameters:
- DW, 16, bus and binary operand width. Only 16 is supported; the digit count is fixed at 5.

Ports:
- CLK  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- d_in  in  16  write data
- cs  in  1  chip select
- addr  in  5  register address
- rd  in  1  read strobe; qualified by cs
- wr  in  1  write strobe; qualified by cs
- d_out  out  16  registered read data
- done  out  1  conversion-complete flag; mirrors STATUS[0]

Behaviour:
- Register map; unlisted addresses read 0 and ignore writes.
  - 0x04 BIN (R/W): operand.
  - 0x0C START (W): write with d_in[0]=1 requests a conversion. Reads {15'b0, busy}.
  - 0x10 BCDLO (R): {d3,d2,d1,d0}.
  - 0x14 BCDHI (R): {12'b0, d4}.
  - 0x18 STATUS (R): {13'b0, sign, busy, done}.
- Write: when cs&wr at a rising edge, the register at addr takes d_in.
- Read: at each rising edge, d_out <= (cs&rd) ? mux(addr) : 16'h0000. Data is valid after the edge where cs&rd is sampled (1-cycle latency).
- If cs, rd and wr are all high: the write takes effect, and the read returns the pre-write value.
- Reset (synchronous): BIN=0, BCD digits=0, shift reg=0, count=0, sign=0, done=0, d_out=0, state=IDLE. Reset asserted mid-conversion aborts it; no partial result remains.
- FSM states: IDLE, LOAD, SHIFT, FIN.
  - IDLE: a START write with d_in[0]=1 at edge E0 moves to LOAD and clears done. A START write with d_in[0]=0 has no effect.
  - LOAD (edge E1): shift reg <= BIN; BCD accumulator <= 0; count <= 0; busy=1; moves to SHIFT.
  - SHIFT (edges E2..E17, 16 iterations): every 4-bit digit >=5 gets +3, then {bcd, shift} shifts left by 1; count increments. When count reaches 15 on an edge, that edge performs the final shift and moves to FIN.
  - FIN: BCDLO/BCDHI hold the result, done=1, busy=0; returns to IDLE on the same edge.
- Latency: done and valid BCD registers are visible after edge E17, i.e. 17 clocks after the START write edge.
- done stays 1 until the next accepted START or reset.
- BCD output registers update only in FIN. During a conversion they keep the previous result, so reads while busy=1 return the old result.
- START while busy=1 is ignored (no restart, no queue).
- A BIN write while busy updates BIN but does not affect the running conversion; the operand was latched in LOAD.
- Range: 0..65535 maps to d4 in 0..6; each digit is 0..9 at all times.

Optional Feature:
- Macro: BCD_SIGNED_EN.
- Defined:
  - BIN is two's complement. LOAD latches sign=BIN[15] and magnitude = sign ? -BIN : BIN.
  - 0x8000 converts to 32768; the magnitude fits 16 bits unsigned.
  - STATUS[2] and BCDHI[15] report sign, updated in FIN.
- Undefined:
  - BIN is unsigned; STATUS[2] and BCDHI[15] read 0.
  - No negation logic is present.

Test Plan:
- Basic: reset; write 0x04=900, 0x0C=1 -> done rises exactly 17 clocks after the START edge; read 0x10=0x0900, 0x14=0x0000, 0x18=0x0001.
- Max value: BIN=65535 -> BCDLO=0x5535, BCDHI=0x0006. Zero: BIN=0 -> BCDLO=0x0000, BCDHI=0x0000, done=1.
- Busy protection: BIN=1234, START; at cycle 5 write BIN=42 and START=1 -> first result 0x1234, no restart. A new START then gives 0x0042.
- Busy reads: during conversion, 0x18 reads 0x0002 and 0x10 returns the previous result. A write 0x0C=0 from IDLE does not start a conversion.
- Reset mid-conversion: assert reset at cycle 8 -> next edge: done=0, STATUS=0, BCDLO=0, d_out=0. A following START with BIN=7 gives 0x0007.
- Signed: BIN=0xFF85.
  - With BCD_SIGNED_EN: BCDLO=0x0123, BCDHI=0x8000, STATUS=0x0005.
  - Without: BCDLO=0x5413, BCDHI=0x0006, STATUS=0x0001.
